// File: rtl/divider_pkg.sv
// Shared CPU definitions for the hi/lo multiply/divide unit.
// Holds the divider FSM encodings, the iteration count and the mfhi/mflo selects.
// Imported by the divider top and any control logic that reads hi/lo.
package divider_pkg;
  localparam int DATA_W    = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

  // Register-select encodings the control unit uses for mfhi/mflo.
  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;
endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate of a 32-bit value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module twos_negate
  import divider_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic              negate,
  output logic [DATA_W-1:0] result
);
  assign result = negate ? (~value + 32'd1) : value;
endmodule

// File: rtl/divider.sv
// Sequential signed 32-bit restoring divider; lo = quotient, hi = remainder.
// Latency: 33 cycles from accepting edge to results (32 iterations + sign fix).
// Backpressure: start is ignored while busy; divide-by-zero completes in one cycle.
module divider
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  logic [1:0]  state;
  logic [31:0] q_reg;
  logic [31:0] m_reg;
  // The partial remainder is always below M between iterations, so 32 bits hold
  // it; the shifted value and the trial subtract carry the extra 33rd bit.
  logic [31:0] r_reg;
  logic [4:0]  count;
  logic        sq;
  logic        sr;

  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] r_shift;
  logic [32:0] trial;
  logic [31:0] lo_fix;
  logic [31:0] hi_fix;

  twos_negate u_abs_dividend (.value(dividend),    .negate(dividend[31]), .result(dividend_abs));
  twos_negate u_abs_divisor  (.value(divisor),     .negate(divisor[31]),  .result(divisor_abs));
  twos_negate u_fix_quot     (.value(q_reg),       .negate(sq),           .result(lo_fix));
  twos_negate u_fix_rem      (.value(r_reg),       .negate(sr),           .result(hi_fix));

  // One restoring step: shift {R,Q} left and trial-subtract the divisor magnitude.
  always_comb begin
    r_shift = {r_reg, q_reg[31]};
    trial   = r_shift - {1'b0, m_reg};
  end

  // FSM and datapath registers; reset aborts any run without producing done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= DIV_IDLE;
      q_reg    <= '0;
      m_reg    <= '0;
      r_reg    <= '0;
      count    <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == 32'd0) begin
              // hi/lo keep the previous result; only the flag and done change.
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              q_reg    <= dividend_abs;
              m_reg    <= divisor_abs;
              sq       <= dividend[31] ^ divisor[31];
              sr       <= dividend[31];
              r_reg    <= '0;
              count    <= '0;
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          count <= count + 5'd1;
          if (!trial[32]) begin
            r_reg <= trial[31:0];
            q_reg <= {q_reg[30:0], 1'b1};
          end else begin
            r_reg <= r_shift[31:0];
            q_reg <= {q_reg[30:0], 1'b0};
          end
          if (count == 5'(DIV_ITERS - 1)) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          lo    <= lo_fix;
          hi    <= hi_fix;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: scoreboard of expected hi/lo/div_zero.
// Expected results come from a signed-arithmetic model evaluated at issue time.
// Outputs are sampled on the falling clock edge.
module tb_divider;
  logic        clk;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  divider dut (
    .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
    .start(start), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compute the expected result, push it, and drive the request.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb_;
    if (b == 32'd0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'd0;
      e.lo = 32'h8000_0000;
      e.dz = 1'b0;
    end else begin
      sa   = a;
      sb_  = b;
      e.lo = sa / sb_;
      e.hi = sa % sb_;
      e.dz = 1'b0;
    end
    model_hi = e.hi;
    model_lo = e.lo;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Wait (bounded) for done, counting latency and busy cycles, then score it.
  task automatic wait_done(output int lat, output int bcnt);
    exp_t e;
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    check_val("done_seen", {31'd0, done}, 32'd1);
    if (done === 1'b1) begin
      check_val("sb_nonempty", sb.size() > 0 ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("lo", lo, e.lo);
        check_val("hi", hi, e.hi);
        check_val("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int lat;
    int bcnt;
    @(negedge clk);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    check_val("latency", lat, (b == 32'd0) ? 32'd0 : 32'd33);
    check_val("busy_cycles", bcnt, (b == 32'd0) ? 32'd0 : 32'd33);
    @(negedge clk);
    check_val("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          bcnt;
    bit          any_done;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic [31:0] ra;
    logic [31:0] rb;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_dz", {31'd0, div_zero}, 32'd0);
    reset = 1'b1;

    // Basic signed cases.
    run_op(32'd100, 32'd7);
    run_op(-32'sd100, 32'd7);
    run_op(32'd100, -32'sd7);
    run_op(-32'sd100, -32'sd7);

    // Divide by zero keeps previous hi/lo; next valid start clears the flag.
    run_op(32'd7, 32'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd5, 32'd9);
    run_op(32'd0, 32'd3);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = {{20{rb[31]}}, rb[11:0]};
      if (rb == 32'd0) rb = 32'd1;
      run_op(ra, rb);
    end

    // Reset in the middle of a run: everything clears, no done follows.
    @(negedge clk);
    issue(32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    check_val("abort_hi", hi, 32'd0);
    check_val("abort_lo", lo, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_dz", {31'd0, div_zero}, 32'd0);
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1'b1;
    end
    check_val("abort_no_done", {31'd0, any_done}, 32'd0);
    run_op(32'd50, 32'd5);

    // start during RUN is ignored; then a back-to-back request on the done edge.
    prev_hi = model_hi;
    prev_lo = model_lo;
    @(negedge clk);
    issue(32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("run_hold_lo", lo, prev_lo);
    check_val("run_hold_hi", hi, prev_hi);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    issue(32'd9, 32'd3);
    @(negedge clk);
    start = 1'b0;
    check_val("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, bcnt);
    check_val("b2b_latency", lat, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Sequential signed 32-bit integer divider for the CPU's MIPS `div` path, the counterpart to the Booth multiplier. It shares the multiplier's `hi`/`lo` result convention: `lo` holds the quotient and `hi` the remainder. It uses a restoring shift-subtract core on operand magnitudes, followed by a sign-fix cycle. It also flags divide-by-zero for the control unit's exception logic.

## Interface
- No parameters; data width is fixed at 32.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising `clk`.
- `dividend` input 32: two's-complement numerator; sampled only on the accepting edge.
- `divisor` input 32: two's-complement denominator; sampled only on the accepting edge.
- `start` input 1: request; accepted only in IDLE.
- `hi` output 32: remainder, signed.
- `lo` output 32: quotient, signed.
- `busy` output 1: high while a division is in progress.
- `done` output 1: one-cycle pulse when `hi`/`lo`/`div_zero` are final.
- `div_zero` output 1: last accepted request had `divisor == 0`; held until the next accepted `start`.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start` + `divisor != 0`:
  - Latch `|dividend|` into Q and `|divisor|` into M as 32-bit unsigned.
  - Latch sign bits `sq = dividend[31] ^ divisor[31]` and `sr = dividend[31]`.
  - Clear the 33-bit partial remainder R, count = 0, `div_zero` = 0.
  - Go to RUN.
- IDLE + `start` + `divisor == 0`:
  - Set `div_zero` = 1 and pulse `done` next cycle.
  - `hi`/`lo` keep their previous values; stay in IDLE.
- RUN, one iteration per cycle:
  - `{R,Q} <= {R,Q} << 1`, then trial `T = R_shifted - {1'b0,M}`.
  - If T is non-negative (bit 32 == 0): R = T and Q[0] = 1; else R is restored and Q[0] = 0.
  - count increments; after the 32nd iteration go to FIX.
- FIX:
  - `lo = sq ? -Q : Q`; `hi = sr ? -R[31:0] : R[31:0]`.
  - Assert `done`; return to IDLE.
- Sign rules: quotient truncates toward zero, and the remainder takes the dividend's sign (MIPS semantics).
- Overflow case `0x80000000 / 0xFFFFFFFF`: magnitudes are 0x80000000 and 1, and `sq` = 0. Result is `lo` = 0x80000000, `hi` = 0, with no flag.
- `start` while `busy` is ignored: operands are not re-sampled and the run is unaffected.
- `hi`/`lo` change only in FIX or under reset. They are stable and readable at all other times, including during RUN.

## Timing
- Reset (`reset` == 0 at an edge) forces, after that edge:
  - state = IDLE;
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0;
  - R, Q, M, count = 0.
- Reset dominates `start` and aborts any run in progress, including mid-RUN and FIX. No `done` is produced for the aborted operation.
- Accepting edge E0 → `busy` = 1 from E0 until E33.
- Edges E1 to E32: the 32 iterations.
- Edge E33: FIX. Results are valid after E33. `done` = 1 and `busy` = 0 for exactly the cycle after E33.
- Total latency is 33 cycles from accept to results.
- A new `start` can be accepted on the edge that ends the `done` cycle, giving back-to-back operation.
- Divide-by-zero: `done` = 1 and `div_zero` = 1 in the cycle after E0, and `busy` is never asserted.
- `done` is never high for more than one consecutive cycle unless a new request completes immediately.

## Structure
- The shared CPU package or header holds:
  - state encodings `DIV_IDLE`, `DIV_RUN`, `DIV_FIX`;
  - constant `DIV_ITERS` = 32;
  - the `hi`/`lo` register-select encodings used by the control unit for mfhi/mflo.
- One optional sub-module, `twos_negate` (32-bit conditional negate, combinational). It is instantiated for the operand absolute values and the FIX sign correction.
- The datapath adder/subtractor is a single 33-bit subtract, kept inline.

## Test plan
- 100 / 7 → after 33 cycles: `lo` = 14, `hi` = 2, `done` single pulse, `busy` high for exactly 33 cycles.
- -100 / 7 → `lo` = 0xFFFFFFF2, `hi` = 0xFFFFFFFE; 100 / -7 → `lo` = 0xFFFFFFF2, `hi` = 2; -100 / -7 → `lo` = 14, `hi` = 0xFFFFFFFE.
- Prior result present, then 7 / 0 → `div_zero` = 1 and `done` one cycle after accept; `busy` never asserted; `hi`/`lo` unchanged. Next valid `start` clears `div_zero`.
- 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0, `div_zero` = 0. Also 5 / 9 → `lo` = 0, `hi` = 5; and 0 / 3 → both 0.
- Start 100 / 7, pulse `reset` low at iteration 10 → all outputs 0 after that edge, no `done`. Then 50 / 5 → `lo` = 10, `hi` = 0.
- Start 100 / 7, assert `start` with 9 / 3 during RUN → result is still 14 / 2. Issuing 9 / 3 on the edge that ends the `done` cycle gives `lo` = 3, `hi` = 0 after 33 more cycles.
